// File: rtl/matrix_pointwise_mac_nxn.sv
// rtl/matrix_pointwise_mac_nxn.sv - NxN Hadamard product / accumulate over LANES time-multiplexed multipliers
module matrix_pointwise_mac_nxn #(
  parameter int N       = 6,
  parameter int DATA_W  = 32,
  parameter int ACC_W   = 64,
  parameter int LANES   = 6,
  parameter int MUL_LAT = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                accumulate,
  input  logic                                signed_mode,
  input  logic [N-1:0][N-1:0][DATA_W-1:0]     a,
  input  logic [N-1:0][N-1:0][DATA_W-1:0]     b,
  output logic [N-1:0][N-1:0][ACC_W-1:0]      c,
  output logic                                busy,
  output logic                                done
);

  localparam int NN    = N * N;
  localparam int K     = NN / LANES;
  localparam int CNT_W = $clog2(K + MUL_LAT + 1);
  localparam int GRP_W = (K > 1) ? $clog2(K) : 1;

  if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
    $error("ACC_W must be at least 2*DATA_W");
  end
  if (NN % LANES != 0) begin : g_bad_lanes
    $error("LANES must divide N*N");
  end
  if (MUL_LAT < 1) begin : g_bad_mul_lat
    $error("MUL_LAT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                                   state_q, state_d;
  logic [CNT_W-1:0]                         cnt_q, cnt_d;
  logic [NN-1:0][DATA_W-1:0]                a_q, a_d, b_q, b_d;
  logic                                     acc_q, acc_d, sgn_q, sgn_d;
  logic                                     iss_vld_q, iss_vld_d;
  logic [GRP_W-1:0]                         iss_grp_q, iss_grp_d;
  logic [LANES-1:0][ACC_W-1:0]              op_a_q, op_a_d, op_b_q, op_b_d;
  logic [MUL_LAT-1:0]                       p_vld_q, p_vld_d;
  logic [MUL_LAT-1:0][GRP_W-1:0]            p_grp_q, p_grp_d;
  logic [MUL_LAT-1:0][LANES-1:0][ACC_W-1:0] p_q, p_d;
  logic [NN-1:0][ACC_W-1:0]                 c_q, c_d;

  function automatic logic [ACC_W-1:0] extend(input logic [DATA_W-1:0] x, input logic sgn);
    return sgn ? {{(ACC_W-DATA_W){x[DATA_W-1]}}, x} : {{(ACC_W-DATA_W){1'b0}}, x};
  endfunction

  // Latched operands shift down one group per ISSUE cycle, so lanes always read the low LANES elements.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    sgn_d     = sgn_q;
    iss_vld_d = 1'b0;
    iss_grp_d = iss_grp_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          cnt_d   = '0;
          a_d     = a;
          b_d     = b;
          acc_d   = accumulate;
          sgn_d   = signed_mode;
        end
      end
      ISSUE: begin
        iss_vld_d = 1'b1;
        iss_grp_d = cnt_q[GRP_W-1:0];
        for (int l = 0; l < LANES; l++) begin
          op_a_d[l] = extend(a_q[l], sgn_q);
          op_b_d[l] = extend(b_q[l], sgn_q);
        end
        a_d = a_q >> (LANES * DATA_W);
        b_d = b_q >> (LANES * DATA_W);
        if (cnt_q == CNT_W'(K - 1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_W'(MUL_LAT)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Multiplier pipeline carries the group tag so write-back knows which elements retire.
  always_comb begin
    p_vld_d    = p_vld_q;
    p_grp_d    = p_grp_q;
    p_d        = p_q;
    p_vld_d[0] = iss_vld_q;
    p_grp_d[0] = iss_grp_q;
    for (int l = 0; l < LANES; l++) begin
      p_d[0][l] = op_a_q[l] * op_b_q[l];
    end
    for (int s = 1; s < MUL_LAT; s++) begin
      p_vld_d[s] = p_vld_q[s-1];
      p_grp_d[s] = p_grp_q[s-1];
      p_d[s]     = p_q[s-1];
    end
  end

  always_comb begin
    c_d = c_q;
    for (int e = 0; e < NN; e++) begin
      if (p_vld_q[MUL_LAT-1] && (p_grp_q[MUL_LAT-1] == GRP_W'(e / LANES))) begin
        c_d[e] = (acc_q ? c_q[e] : '0) + p_q[MUL_LAT-1][e % LANES];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= 1'b0;
      sgn_q     <= 1'b0;
      iss_vld_q <= 1'b0;
      iss_grp_q <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      p_vld_q   <= '0;
      p_grp_q   <= '0;
      p_q       <= '0;
      c_q       <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      sgn_q     <= sgn_d;
      iss_vld_q <= iss_vld_d;
      iss_grp_q <= iss_grp_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      p_vld_q   <= p_vld_d;
      p_grp_q   <= p_grp_d;
      p_q       <= p_d;
      c_q       <= c_d;
    end
  end

  assign c    = c_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_matrix_pointwise_mac_nxn.sv
// tb/tb_matrix_pointwise_mac_nxn.sv - scoreboard bench for matrix_pointwise_mac_nxn
module tb_matrix_pointwise_mac_nxn;

  typedef logic [5:0][5:0][31:0] tile_t;
  typedef struct {
    logic [35:0][63:0] c;
    int                done_at;
  } exp_t;

  logic clk;
  logic rst_n, start, accumulate, signed_mode;
  tile_t a_in, b_in;
  logic [5:0][5:0][63:0] c_out;
  logic busy, done;

  logic [3:0][3:0][31:0] a4;
  logic [3:0][3:0][63:0] c4;
  logic start4, busy4, done4;
  logic [7:0][7:0][31:0] a8;
  logic [7:0][7:0][63:0] c8;
  logic start8, busy8, done8;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic [35:0][63:0] model_c;

  matrix_pointwise_mac_nxn u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .accumulate(accumulate), .signed_mode(signed_mode),
    .a(a_in), .b(b_in), .c(c_out), .busy(busy), .done(done)
  );

  matrix_pointwise_mac_nxn #(.N(4), .LANES(4), .MUL_LAT(3)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .accumulate(accumulate), .signed_mode(signed_mode),
    .a(a4), .b(a4), .c(c4), .busy(busy4), .done(done4)
  );

  matrix_pointwise_mac_nxn #(.N(8), .LANES(64), .MUL_LAT(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .accumulate(accumulate), .signed_mode(signed_mode),
    .a(a8), .b(a8), .c(c8), .busy(busy8), .done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ext(input logic [31:0] x, input bit sgn);
    return sgn ? {{32{x[31]}}, x} : {32'b0, x};
  endfunction

  function automatic tile_t seq_tile();
    tile_t t;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) t[i][j] = 32'(i * 6 + j + 1);
    return t;
  endfunction

  function automatic tile_t fill_tile(input logic [31:0] x);
    tile_t t;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) t[i][j] = x;
    return t;
  endfunction

  task automatic push_exp(input tile_t ta, input tile_t tb, input bit acc, input bit sgn, input int done_at);
    exp_t e;
    for (int k = 0; k < 36; k++)
      e.c[k] = (acc ? model_c[k] : 64'd0) + ext(ta[k/6][k%6], sgn) * ext(tb[k/6][k%6], sgn);
    model_c   = e.c;
    e.done_at = done_at;
    sb_q.push_back(e);
  endtask

  // Call right after a negedge; start is accepted at the next posedge (T = cyc+1), done expected at T+10.
  task automatic drive_start(input tile_t ta, input tile_t tb, input bit acc, input bit sgn, input bit push);
    a_in = ta; b_in = tb; accumulate = acc; signed_mode = sgn; start = 1'b1;
    if (push) push_exp(ta, tb, acc, sgn, cyc + 1 + 10);
  endtask

  task automatic run_wait();
    bit seen = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done) seen = 1;
    end
    if (!seen) check_val("done_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  task automatic run(input tile_t ta, input tile_t tb, input bit acc, input bit sgn);
    drive_start(ta, tb, acc, sgn, 1);
    run_wait();
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("done_cycle", 64'(cyc + 1), 64'(mon_e.done_at));
        for (int k = 0; k < 36; k++)
          check_val($sformatf("c[%0d][%0d]", k / 6, k % 6), c_out[k/6][k%6], mon_e.c[k]);
      end
    end
  end

  initial begin
    int dn, t0, first;
    rst_n = 1'b0; start = 1'b0; start4 = 1'b0; start8 = 1'b0;
    accumulate = 1'b0; signed_mode = 1'b0;
    a_in = '0; b_in = '0; a4 = '0; a8 = '0;
    model_c = '0;
    repeat (2) @(negedge clk);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    for (int k = 0; k < 36; k++) check_val("rst_c", c_out[k/6][k%6], 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // zero tiles with busy/done window
    drive_start(fill_tile(0), fill_tile(0), 0, 0, 1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      check_val($sformatf("zero_busy_T+%0d", k), 64'(busy), 64'(k <= 10));
      check_val($sformatf("zero_done_T+%0d", k), 64'(done), 64'(k == 10));
    end

    run(seq_tile(), seq_tile(), 0, 0);
    check_val("seq_c00", c_out[0][0], 64'd1);
    check_val("seq_c23", c_out[2][3], 64'd256);
    check_val("seq_c55", c_out[5][5], 64'd1296);
    run(seq_tile(), seq_tile(), 1, 0);
    check_val("acc_c55", c_out[5][5], 64'd2592);
    check_val("acc_c00", c_out[0][0], 64'd2);

    run(fill_tile(32'hFFFFFFFD), fill_tile(4), 0, 1);
    check_val("signed_c00", c_out[0][0], 64'hFFFFFFFFFFFFFFF4);
    run(fill_tile(32'hFFFFFFFD), fill_tile(4), 0, 0);
    check_val("unsigned_c34", c_out[3][4], 64'h00000003FFFFFFF4);
    run(fill_tile(32'hFFFFFFFF), fill_tile(32'hFFFFFFFF), 0, 0);
    check_val("max_c55", c_out[5][5], 64'hFFFFFFFE00000001);

    // start re-pulsed mid-run is ignored
    drive_start(seq_tile(), seq_tile(), 0, 0, 1);
    dn = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 3) begin a_in = fill_tile(7); b_in = fill_tile(9); start = 1'b1; end
      if (k == 4) start = 1'b0;
      if (done) dn++;
    end
    check_val("ignored_start_dones", 64'(dn), 64'd1);
    check_val("ignored_start_c55", c_out[5][5], 64'd1296);

    // start held high through done: second run accepted at T+11
    t0 = cyc + 1;
    drive_start(fill_tile(3), fill_tile(5), 0, 1, 1);
    dn = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 5) begin
        a_in = seq_tile(); b_in = fill_tile(2); accumulate = 1'b1; signed_mode = 1'b0;
        push_exp(seq_tile(), fill_tile(2), 1, 0, t0 + 21);
      end
      if (k == 11) check_val("held_idle_busy", 64'(busy), 64'd0);
      if (k == 12) start = 1'b0;
      if (done) dn++;
    end
    check_val("held_start_dones", 64'(dn), 64'd2);
    check_val("held_c55", c_out[5][5], 64'd87);

    // asynchronous reset mid-run
    drive_start(seq_tile(), seq_tile(), 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy", 64'(busy), 64'd0);
    check_val("midrst_done", 64'(done), 64'd0);
    for (int k = 0; k < 36; k++) check_val("midrst_c", c_out[k/6][k%6], 64'd0);
    model_c = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      check_val("no_done_after_rst", 64'(done), 64'd0);
    end
    run(seq_tile(), seq_tile(), 1, 0);
    check_val("post_rst_c55", c_out[5][5], 64'd1296);

    // N=4, LANES=4, MUL_LAT=3: done at T+9
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) a4[i][j] = 32'(i * 4 + j + 1);
    accumulate = 1'b0; signed_mode = 1'b0;
    start4 = 1'b1; t0 = cyc + 1; first = -1; dn = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) start4 = 1'b0;
      if (done4) begin dn++; if (first < 0) first = cyc + 1; end
    end
    check_val("sw4_done_at", 64'(first), 64'(t0 + 9));
    check_val("sw4_dones", 64'(dn), 64'd1);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        check_val($sformatf("sw4_c[%0d][%0d]", i, j), c4[i][j], 64'((i * 4 + j + 1) * (i * 4 + j + 1)));

    // N=8, LANES=64, MUL_LAT=1: done at T+4
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) a8[i][j] = 32'(i * 8 + j + 1);
    start8 = 1'b1; t0 = cyc + 1; first = -1; dn = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start8 = 1'b0;
      if (done8) begin dn++; if (first < 0) first = cyc + 1; end
    end
    check_val("sw8_done_at", 64'(first), 64'(t0 + 4));
    check_val("sw8_dones", 64'(dn), 64'd1);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        check_val($sformatf("sw8_c[%0d][%0d]", i, j), c8[i][j], 64'((i * 8 + j + 1) * (i * 8 + j + 1)));

    repeat (3) @(negedge clk);
    check_val("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
